// File: rtl/hazard_scoreboard_if.sv
// Pipeline hazard bus: stage register fields into the scoreboard and
// forward/stall/flush controls back out to the pipeline.
interface hazard_scoreboard_if #(
  parameter int NLANES = 2,
  parameter int RW     = 4,
  parameter int FW     = $clog2(2*NLANES+1)
);
  logic [NLANES*2*RW-1:0] d_src;
  logic [NLANES*2-1:0]    d_src_vld;
  logic [NLANES*RW-1:0]   d_dst;
  logic [NLANES-1:0]      d_we;
  logic [NLANES-1:0]      d_long;
  logic [NLANES*2*RW-1:0] e_src;
  logic [NLANES*2-1:0]    e_src_vld;
  logic [NLANES*RW-1:0]   e_dst;
  logic [NLANES-1:0]      e_we;
  logic [NLANES-1:0]      e_load;
  logic                   e_long_issue;
  logic [RW-1:0]          e_long_dst;
  logic [NLANES*RW-1:0]   m_dst;
  logic [NLANES-1:0]      m_we;
  logic [NLANES*RW-1:0]   w_dst;
  logic [NLANES-1:0]      w_we;
  logic                   branch_taken_e;
  logic [NLANES*FW-1:0]   fwd_a;
  logic [NLANES*FW-1:0]   fwd_b;
  logic                   stall_f;
  logic                   stall_d;
  logic                   flush_d;
  logic                   flush_e;
  logic                   long_busy;
  logic                   long_wb;
  logic [RW-1:0]          long_wb_dst;

  modport master (
    output d_src, d_src_vld, d_dst, d_we, d_long,
    output e_src, e_src_vld, e_dst, e_we, e_load, e_long_issue, e_long_dst,
    output m_dst, m_we, w_dst, w_we, branch_taken_e,
    input  fwd_a, fwd_b, stall_f, stall_d, flush_d, flush_e,
    input  long_busy, long_wb, long_wb_dst
  );

  modport slave (
    input  d_src, d_src_vld, d_dst, d_we, d_long,
    input  e_src, e_src_vld, e_dst, e_we, e_load, e_long_issue, e_long_dst,
    input  m_dst, m_we, w_dst, w_we, branch_taken_e,
    output fwd_a, fwd_b, stall_f, stall_d, flush_d, flush_e,
    output long_busy, long_wb, long_wb_dst
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Multi-lane hazard unit: E-stage forwarding selects, load-use stall FSM and
// a single-entry long-latency scoreboard with its own writeback pulse.
module hazard_scoreboard #(
  parameter int NLANES  = 2,
  parameter int RW      = 4,
  parameter int LOADLAT = 1,
  parameter int LONGLAT = 4,
  parameter int FW      = $clog2(2*NLANES+1)
) (
  input logic           clk,
  input logic           reset,
  hazard_scoreboard_if.slave hz
);
  localparam int CW  = $clog2(LONGLAT);
  localparam int LCW = (LOADLAT > 1) ? $clog2(LOADLAT) : 1;

  typedef enum logic {LD_IDLE, LD_WAIT} ld_state_t;

  ld_state_t            ld_state, ld_state_next;
  logic [LCW-1:0]       ldcnt, ldcnt_next;
  logic                 ld_stall;
  logic                 load_use;
  logic                 busy;
  logic [CW-1:0]        cnt;
  logic [RW-1:0]        pdst;
  logic                 sb_hit;
  logic                 sb_stall;
  logic                 hold;
  logic                 wb;
  logic [FW-1:0]        sel_tmp;
  logic [NLANES*FW-1:0] fwd_a_c;
  logic [NLANES*FW-1:0] fwd_b_c;

  // Later matches override earlier ones: W before M, older lane before younger
  always_comb begin
    fwd_a_c = '0;
    fwd_b_c = '0;
    sel_tmp = '0;
    for (int g = 0; g < 2*NLANES; g++) begin
      sel_tmp = '0;
      if (hz.e_src_vld[g]) begin
        for (int k = 0; k < NLANES; k++)
          if (hz.w_we[k] && hz.w_dst[k*RW +: RW] == hz.e_src[g*RW +: RW])
            sel_tmp = FW'(NLANES + k + 1);
        for (int k = 0; k < NLANES; k++)
          if (hz.m_we[k] && hz.m_dst[k*RW +: RW] == hz.e_src[g*RW +: RW])
            sel_tmp = FW'(k + 1);
      end
      if (g % 2 == 0) fwd_a_c[(g/2)*FW +: FW] = sel_tmp;
      else            fwd_b_c[(g/2)*FW +: FW] = sel_tmp;
    end
  end

  assign hz.fwd_a = fwd_a_c;
  assign hz.fwd_b = fwd_b_c;

  always_comb begin
    load_use = 1'b0;
    for (int e = 0; e < NLANES; e++)
      if (hz.e_load[e] && hz.e_we[e])
        for (int s = 0; s < 2*NLANES; s++)
          if (hz.d_src_vld[s] && hz.d_src[s*RW +: RW] == hz.e_dst[e*RW +: RW])
            load_use = 1'b1;
    if (hz.branch_taken_e) load_use = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_state <= LD_IDLE;
      ldcnt    <= '0;
    end else begin
      ld_state <= ld_state_next;
      ldcnt    <= ldcnt_next;
    end
  end

  // The hazard cycle itself is the first stall cycle; LD_WAIT covers the rest
  always_comb begin
    ld_state_next = ld_state;
    ldcnt_next    = ldcnt;
    ld_stall      = 1'b0;
    case (ld_state)
      LD_IDLE: begin
        if (load_use) begin
          ld_stall = 1'b1;
          if (LOADLAT > 1) begin
            ld_state_next = LD_WAIT;
            ldcnt_next    = LCW'(LOADLAT - 1);
          end
        end
      end
      LD_WAIT: begin
        if (hz.branch_taken_e) begin
          ld_state_next = LD_IDLE;
          ldcnt_next    = '0;
        end else begin
          ld_stall = 1'b1;
          if (ldcnt <= LCW'(1)) begin
            ld_state_next = LD_IDLE;
            ldcnt_next    = '0;
          end else begin
            ldcnt_next = ldcnt - LCW'(1);
          end
        end
      end
      default: begin
        ld_state_next = LD_IDLE;
        ldcnt_next    = '0;
      end
    endcase
  end

  // A second issue while busy is dropped; branches never cancel the op
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      pdst <= '0;
    end else if (busy) begin
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - CW'(1);
    end else if (hz.e_long_issue && !hz.branch_taken_e) begin
      busy <= 1'b1;
      cnt  <= CW'(LONGLAT - 1);
      pdst <= hz.e_long_dst;
    end
  end

  always_comb begin
    sb_hit = 1'b0;
    for (int l = 0; l < NLANES; l++) begin
      if (hz.d_long[l]) sb_hit = 1'b1;
      if (hz.d_we[l] && hz.d_dst[l*RW +: RW] == pdst) sb_hit = 1'b1;
      for (int s = 0; s < 2; s++)
        if (hz.d_src_vld[2*l+s] && hz.d_src[(2*l+s)*RW +: RW] == pdst)
          sb_hit = 1'b1;
    end
  end

  assign sb_stall = busy && sb_hit;
  assign hold     = !reset && !hz.branch_taken_e && (ld_stall || sb_stall);
  assign wb       = !reset && busy && (cnt == '0);

  assign hz.stall_f     = hold;
  assign hz.stall_d     = hold;
  assign hz.flush_d     = !reset && hz.branch_taken_e;
  assign hz.flush_e     = !reset && (hz.branch_taken_e || ld_stall);
  assign hz.long_busy   = busy;
  assign hz.long_wb     = wb;
  assign hz.long_wb_dst = wb ? pdst : '0;
endmodule
